// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer: opcode encodings, instruction
// field positions, sequencer state type and default program bound.
package cpu_pkg;

  localparam int LAST_ADDR_DEF = 127;

  // Instruction field bit positions (16-bit instruction word)
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int DEST_HI = 11;
  localparam int DEST_LO = 8;
  localparam int SRC1_HI = 7;
  localparam int SRC1_LO = 4;
  localparam int SRC2_HI = 3;
  localparam int SRC2_LO = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  // Control opcodes handled inside the sequencer
  localparam logic [3:0] OP_HALT  = 4'b1110;
  localparam logic [3:0] OP_JUMP  = 4'b1101;
  localparam logic [3:0] OP_COND  = 4'b1111;
  // Reserved encodings that stop the machine
  localparam logic [3:0] OP_ILL_A = 4'b1001;
  localparam logic [3:0] OP_ILL_B = 4'b1010;
  localparam logic [3:0] OP_ILL_C = 4'b1100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    HALTED = 3'd4
  } seqState_t;

endpackage

// File: rtl/instr_field_decoder.sv
// Splits the held instruction word into fields and classifies the opcode.
module instr_field_decoder
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         dest,
  output logic [3:0]         src1,
  output logic [3:0]         src2,
  output logic [7:0]         imm,
  output logic               isHalt,
  output logic               isJump,
  output logic               isCond,
  output logic               isIllegal,
  output logic               isIssue
);

  assign opcode = ir[OPC_HI:OPC_LO];
  assign dest   = ir[DEST_HI:DEST_LO];
  assign src1   = ir[SRC1_HI:SRC1_LO];
  assign src2   = ir[SRC2_HI:SRC2_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

  // Exactly one class flag is raised for every opcode
  always_comb begin
    isHalt    = 1'b0;
    isJump    = 1'b0;
    isCond    = 1'b0;
    isIllegal = 1'b0;
    isIssue   = 1'b0;
    case (opcode)
      OP_HALT:                      isHalt    = 1'b1;
      OP_JUMP:                      isJump    = 1'b1;
      OP_COND:                      isCond    = 1'b1;
      OP_ILL_A, OP_ILL_B, OP_ILL_C: isIllegal = 1'b1;
      default:                      isIssue   = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/issue sequencer: walks instruction memory from address 0,
// resolves halt/jump/conditional-halt locally and offers everything else to
// the execute stage through a valid/ready handshake.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 16,
  parameter int LAST_ADDR = LAST_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        issue_opcode,
  output logic [3:0]        issue_dest,
  output logic [3:0]        issue_src1,
  output logic [3:0]        issue_src2,
  output logic [7:0]        issue_imm,
  output logic [3:0]        cond_sel,
  input  logic [7:0]        cond_value,
  output logic              halted,
  output logic              fault,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  seqState_t          state, stateNext;
  logic [INSTR_W-1:0] ir, irNext;
  logic [ADDR_W-1:0]  pcNext;
  logic [15:0]        cntNext;
  logic               faultNext, illegalNext;

  logic [3:0] opcode, dest, src1, src2;
  logic [7:0] imm;
  logic       isHalt, isJump, isCond, isIllegal, isIssue;

  instr_field_decoder #(.INSTR_W(INSTR_W)) uDec (
    .ir        (ir),
    .opcode    (opcode),
    .dest      (dest),
    .src1      (src1),
    .src2      (src2),
    .imm       (imm),
    .isHalt    (isHalt),
    .isJump    (isJump),
    .isCond    (isCond),
    .isIllegal (isIllegal),
    .isIssue   (isIssue)
  );

  assign instr_addr   = pc;
  assign issue_valid  = (state == ISSUE);
  assign issue_opcode = opcode;
  assign issue_dest   = dest;
  assign issue_src1   = src1;
  assign issue_src2   = src2;
  assign issue_imm    = imm;
  assign cond_sel     = (state == DECODE) ? src2 : 4'd0;
  assign halted       = (state == HALTED);

  // State and datapath registers; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      pc          <= '0;
      instr_count <= '0;
      fault       <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= stateNext;
      ir          <= irNext;
      pc          <= pcNext;
      instr_count <= cntNext;
      fault       <= faultNext;
      illegal     <= illegalNext;
    end
  end

  // Next-state and datapath updates; stepping past LAST_PC faults with pc held
  always_comb begin
    stateNext   = state;
    irNext      = ir;
    pcNext      = pc;
    cntNext     = instr_count;
    faultNext   = fault;
    illegalNext = illegal;
    case (state)
      IDLE: begin
        pcNext = '0;
        if (run) stateNext = FETCH;
      end
      FETCH: begin
        irNext    = instr_data;
        stateNext = DECODE;
      end
      DECODE: begin
        if (isHalt) begin
          stateNext = HALTED;
        end else if (isJump) begin
          if (32'(imm) > LAST_ADDR) begin
            stateNext = HALTED;
            faultNext = 1'b1;
          end else begin
            pcNext    = ADDR_W'(imm);
            stateNext = FETCH;
          end
        end else if (isCond) begin
          if (cond_value == 8'd0) begin
            stateNext = HALTED;
          end else if (pc == LAST_PC) begin
            stateNext = HALTED;
            faultNext = 1'b1;
          end else begin
            pcNext    = pc + ADDR_W'(1);
            stateNext = FETCH;
          end
        end else if (isIllegal) begin
          stateNext   = HALTED;
          illegalNext = 1'b1;
        end else if (isIssue) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          if (instr_count != 16'hFFFF) cntNext = instr_count + 16'd1;
          if (pc == LAST_PC) begin
            stateNext = HALTED;
            faultNext = 1'b1;
          end else begin
            pcNext    = pc + ADDR_W'(1);
            stateNext = FETCH;
          end
        end
      end
      default: ;  // HALTED: only reset leaves
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a small instruction memory model,
// an expected-issue queue checked on every handshake, and directed programs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_opcode, issue_dest, issue_src1, issue_src2;
  logic [7:0]  issue_imm;
  logic [3:0]  cond_sel;
  logic [7:0]  cond_value;
  logic        halted, fault, illegal;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  logic [15:0] mem [0:255];
  logic [23:0] sbQ [$];
  int          nChecks = 0;
  int          nFail   = 0;

  always #5 clk = ~clk;

  assign instr_data = mem[instr_addr];

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_opcode (issue_opcode),
    .issue_dest   (issue_dest),
    .issue_src1   (issue_src1),
    .issue_src2   (issue_src2),
    .issue_imm    (issue_imm),
    .cond_sel     (cond_sel),
    .cond_value   (cond_value),
    .halted       (halted),
    .fault        (fault),
    .illegal      (illegal),
    .pc           (pc),
    .instr_count  (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] fieldsOf(input logic [15:0] w);
    return {w[15:12], w[11:8], w[7:4], w[3:0], w[7:0]};
  endfunction

  // Every accepted issue must match the oldest expected instruction
  always @(negedge clk) begin
    if (!reset && issue_valid && issue_ready) begin
      if (sbQ.size() == 0) chk("issue_unexpected_qsize", 0, 1);
      else chk("issue_fields", {issue_opcode, issue_dest, issue_src1, issue_src2, issue_imm},
               sbQ.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic doReset();
    reset = 1'b1; run = 1'b0; issue_ready = 1'b0;
    step(1);
    reset = 1'b0;
    sbQ.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  task automatic pulseRun();
    run = 1'b1;
    step(1);
    run = 1'b0;
  endtask

  task automatic waitHalt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin step(1); n++; end
    if (!halted) chk(tag, halted, 1);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; issue_ready = 1'b0; cond_value = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    #2;
    // Reset values
    chk("rst_pc", pc, 0);
    chk("rst_addr", instr_addr, 0);
    chk("rst_valid", issue_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", {fault, illegal}, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_condsel", cond_sel, 0);

    // Nothing happens until run
    doReset();
    step(4);
    chk("idle_pc", pc, 0);
    chk("idle_halted", halted, 0);

    // Two issues then halt
    doReset();
    mem[0] = 16'h1100; mem[1] = 16'h0200; mem[2] = 16'hE000;
    sbQ.push_back(fieldsOf(16'h1100));
    sbQ.push_back(fieldsOf(16'h0200));
    issue_ready = 1'b1;
    pulseRun();
    waitHalt("prog1_halt_timeout", 40);
    chk("prog1_halted", halted, 1);
    chk("prog1_pc", pc, 2);
    chk("prog1_count", instr_count, 2);
    chk("prog1_qleft", sbQ.size(), 0);
    chk("prog1_flags", {fault, illegal}, 0);

    // Jump then halt, cycle exact
    doReset();
    mem[0] = 16'hD005; mem[5] = 16'hE000;
    issue_ready = 1'b1;
    pulseRun();                       // now FETCH @0
    chk("jmp_addr0", instr_addr, 0);
    step(1);                          // DECODE
    step(1);                          // FETCH @5
    chk("jmp_addr5", instr_addr, 5);
    step(1);                          // DECODE
    chk("jmp_not_yet_halted", halted, 0);
    step(1);                          // HALTED, 4 cycles after first FETCH
    chk("jmp_halted", halted, 1);
    chk("jmp_pc", pc, 5);
    chk("jmp_count", instr_count, 0);

    // Conditional halt taken
    doReset();
    mem[0] = 16'hF004; cond_value = 8'd0;
    pulseRun();
    step(1);
    chk("cond0_sel", cond_sel, 4);
    step(1);
    chk("cond0_halted", halted, 1);
    chk("cond0_pc", pc, 0);
    chk("cond0_condsel_after", cond_sel, 0);

    // Conditional halt not taken
    doReset();
    mem[0] = 16'hF004; cond_value = 8'd3;
    pulseRun();
    chk("cond3_sel_fetch", cond_sel, 0);
    step(1);
    chk("cond3_sel", cond_sel, 4);
    step(1);
    chk("cond3_pc", pc, 1);
    chk("cond3_halted", halted, 0);
    waitHalt("cond3_halt_timeout", 10);
    chk("cond3_count", instr_count, 0);

    // Backpressure: held offer stays stable
    doReset();
    mem[0] = 16'h3456; mem[1] = 16'hE000;
    issue_ready = 1'b0;
    pulseRun();
    step(2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", issue_valid, 1);
      chk("bp_fields", {issue_opcode, issue_dest, issue_src1, issue_src2, issue_imm},
          fieldsOf(16'h3456));
      chk("bp_pc", pc, 0);
      chk("bp_count", instr_count, 0);
      run = 1'b1;                     // run outside IDLE has no effect
      step(1);
      run = 1'b0;
    end
    sbQ.push_back(fieldsOf(16'h3456));
    issue_ready = 1'b1;
    step(1);
    chk("bp_pc_after", pc, 1);
    chk("bp_count_after", instr_count, 1);
    chk("bp_valid_after", issue_valid, 0);
    waitHalt("bp_halt_timeout", 10);
    chk("bp_qleft", sbQ.size(), 0);

    // Illegal opcode, sticky while halted
    doReset();
    mem[0] = 16'h9000;
    issue_ready = 1'b1;
    pulseRun();
    step(2);
    chk("ill_halted", halted, 1);
    chk("ill_flags", {fault, illegal}, 2'b01);
    pulseRun();
    step(2);
    chk("ill_sticky", {halted, fault, illegal}, 3'b101);
    chk("ill_count", instr_count, 0);

    // Jump out of range
    doReset();
    chk("jf_rst_flags", {fault, illegal}, 0);
    mem[0] = 16'hD0C8;
    pulseRun();
    step(2);
    chk("jf_halted", halted, 1);
    chk("jf_flags", {fault, illegal}, 2'b10);
    chk("jf_pc", pc, 0);

    // Issue at the last address faults with pc held
    doReset();
    mem[0] = 16'hD07F; mem[127] = 16'h2000;
    sbQ.push_back(fieldsOf(16'h2000));
    issue_ready = 1'b1;
    pulseRun();
    waitHalt("last_halt_timeout", 20);
    chk("last_fault", fault, 1);
    chk("last_pc", pc, 127);
    chk("last_count", instr_count, 1);
    chk("last_qleft", sbQ.size(), 0);

    // Conditional continue at the last address faults too
    doReset();
    mem[0] = 16'hD07F; mem[127] = 16'hF001; cond_value = 8'd9;
    pulseRun();
    waitHalt("lastc_halt_timeout", 20);
    chk("lastc_fault", fault, 1);
    chk("lastc_pc", pc, 127);

    // Reset in the middle of a held offer
    doReset();
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    sbQ.push_back(fieldsOf(16'h1234));
    issue_ready = 1'b1;
    pulseRun();
    step(3);                          // first issue accepted, now FETCH @1
    issue_ready = 1'b0;
    step(2);                          // ISSUE for second word
    chk("mid_valid", issue_valid, 1);
    chk("mid_count", instr_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", issue_valid, 0);
    chk("mid_rst_pc", {pc, instr_addr}, 0);
    chk("mid_rst_count", instr_count, 0);
    chk("mid_rst_fields", {issue_opcode, issue_dest, issue_src1, issue_src2, issue_imm}, 0);
    chk("mid_rst_status", {halted, fault, illegal, cond_sel}, 0);
    step(1);
    reset = 1'b0;
    step(3);
    chk("mid_idle_pc", pc, 0);
    chk("mid_idle_valid", issue_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
